// File: rtl/adder_seq_pkg.sv
// Shared types and default sizing for the sequenced 64-bit adder.
package adder_seq_pkg;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_SLICE = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple-carry adder built from full-adder cells.
module adder_slice #(
  parameter int unsigned SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in,
  output logic [SLICE-1:0] sum,
  output logic             c_out
);

  logic [SLICE:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[SLICE];

endmodule

// File: rtl/adder64_sequencer.sv
// Multi-cycle adder: one SLICE-bit adder stepped LSB to MSB, carry held in a
// register between slices, result and carry-out published only on completion.
module adder64_sequencer
  import adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned OFF_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nx_c;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [OFF_W-1:0] off_c;
  logic [SLICE-1:0] slice_sum_c;
  logic             slice_co_c;
  logic             accept_c, last_c;

  assign accept_c = start && (state == S_IDLE || state == S_DONE);
  assign last_c   = (idx_q == IDX_LAST);
  assign off_c    = OFF_W'(idx_q) * OFF_W'(SLICE);

  adder_slice #(.SLICE(SLICE)) u_slice (
    .a     (a_q[off_c +: SLICE]),
    .b     (b_q[off_c +: SLICE]),
    .c_in  (carry_q),
    .sum   (slice_sum_c),
    .c_out (slice_co_c)
  );

  // Accumulator with the current slice merged in; also the final sum at the last slice.
  always_comb begin
    acc_nx_c = acc_q;
    acc_nx_c[off_c +: SLICE] = slice_sum_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last_c) state_nx = S_DONE;
      S_DONE:  state_nx = start ? S_RUN : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand, slice-step and output registers; index wraps only via the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
    end else begin
      busy <= (state_nx == S_RUN);
      done <= (state_nx == S_DONE);
      if (accept_c) begin
        a_q     <= a;
        b_q     <= b;
        carry_q <= c_in;
        idx_q   <= '0;
        acc_q   <= '0;
      end else if (state == S_RUN) begin
        acc_q   <= acc_nx_c;
        carry_q <= slice_co_c;
        idx_q   <= last_c ? '0 : idx_q + IDX_W'(1);
        if (last_c) begin
          sum   <= acc_nx_c;
          c_out <= slice_co_c;
        end
      end
    end
  end

endmodule
